// File: rtl/burst_ctrl_pkg.sv
// Shared types for the burst read controller: FSM state encoding and the
// channel-select width helper.
package burst_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      GAP  = 2'd2
   } state_t;

   // A single channel still gets a 1-bit select so ports never collapse to zero width
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel
// after last_grant, wrapping modulo NUM_CH.
module rr_arbiter #(
   parameter int NUM_CH = 2,
   parameter int SEL_W  = 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  last_grant,
   output logic [NUM_CH-1:0] grant,
   output logic [SEL_W-1:0]  grant_idx,
   output logic              valid
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
         int idx;
         idx = (int'(last_grant) + k) % NUM_CH;
         if (!valid && req[idx]) begin
            valid      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = SEL_W'(idx);
         end
      end
   end

endmodule

// File: rtl/burst_read_ctrl.sv
// Burst read controller: grants one FIFO channel at a time round-robin, streams
// BURST_LEN beats to the Ethernet path, then idles GAP_LEN cycles.
//
// state | meaning
// IDLE  | waiting for a channel that is full and not empty
// READ  | streaming beats from ch_sel; stalls on !eth_ready, aborts on empty
// GAP   | mandatory idle cycles after a complete burst
module burst_read_ctrl
   import burst_ctrl_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int BURST_LEN = 512,
   parameter int GAP_LEN   = 2048,
   parameter int CNT_W     = 12,
   localparam int SEL_W    = sel_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NUM_CH-1:0] full,
   input  logic [NUM_CH-1:0] empty,
   input  logic              eth_ready,
   output logic [NUM_CH-1:0] rd_en,
   output logic              eth_en,
   output logic [SEL_W-1:0]  ch_sel,
   output logic              sop,
   output logic              eop,
   output logic              abort
);

   state_t            state;
   logic [SEL_W-1:0]  last_grant;
   logic [NUM_CH-1:0] sel_oh;
   logic [CNT_W-1:0]  beat_cnt;
   logic [CNT_W-1:0]  gap_cnt;

   logic [NUM_CH-1:0] arb_req;
   logic [NUM_CH-1:0] arb_grant;
   logic [SEL_W-1:0]  arb_idx;
   logic              arb_valid;

   logic cur_empty;
   logic beat;
   logic last_beat;

   assign arb_req = full & ~empty;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_arb (
      .req        (arb_req),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .grant_idx  (arb_idx),
      .valid      (arb_valid)
   );

   // Empty wins over eth_ready so a drained FIFO is never read
   assign cur_empty = empty[ch_sel];
   assign beat      = (state == READ) && eth_ready && !cur_empty;
   assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));

   assign eth_en = beat;
   assign rd_en  = beat ? sel_oh : '0;
   assign sop    = beat && (beat_cnt == '0);
   assign eop    = beat && last_beat;
   assign abort  = (state == READ) && cur_empty;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         ch_sel     <= '0;
         last_grant <= SEL_W'(NUM_CH - 1);
         sel_oh     <= '0;
         beat_cnt   <= '0;
         gap_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  state      <= READ;
                  ch_sel     <= arb_idx;
                  last_grant <= arb_idx;
                  sel_oh     <= arb_grant;
               end
            end
            READ: begin
               if (cur_empty) begin
                  state    <= IDLE;
                  beat_cnt <= '0;
               end else if (eth_ready) begin
                  if (last_beat) begin
                     beat_cnt <= '0;
                     gap_cnt  <= '0;
                     state    <= (GAP_LEN == 0) ? IDLE : GAP;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == CNT_W'(GAP_LEN - 1)) begin
                  gap_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_burst_read_ctrl.sv
// Directed bench for burst_read_ctrl: three instances cover single-channel
// bursts with gap, three-channel round-robin, and single-beat bursts.
module tb_burst_read_ctrl;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // a: NUM_CH=1, BURST_LEN=4, GAP_LEN=3
   logic       a_full, a_empty, a_ready;
   logic [0:0] a_rd_en;
   logic       a_eth_en, a_sop, a_eop, a_abort;
   logic [0:0] a_ch_sel;

   // b: NUM_CH=3, BURST_LEN=4, GAP_LEN=2
   logic [2:0] b_full, b_empty, b_rd_en;
   logic       b_ready, b_eth_en, b_sop, b_eop, b_abort;
   logic [1:0] b_ch_sel;

   // c: NUM_CH=1, BURST_LEN=1, GAP_LEN=0
   logic       c_full, c_empty, c_ready;
   logic [0:0] c_rd_en;
   logic       c_eth_en, c_sop, c_eop, c_abort;
   logic [0:0] c_ch_sel;

   burst_read_ctrl #(.NUM_CH(1), .BURST_LEN(4), .GAP_LEN(3), .CNT_W(3)) u_a (
      .clk(clk), .rstn(rstn), .full(a_full), .empty(a_empty), .eth_ready(a_ready),
      .rd_en(a_rd_en), .eth_en(a_eth_en), .ch_sel(a_ch_sel), .sop(a_sop),
      .eop(a_eop), .abort(a_abort));

   burst_read_ctrl #(.NUM_CH(3), .BURST_LEN(4), .GAP_LEN(2), .CNT_W(3)) u_b (
      .clk(clk), .rstn(rstn), .full(b_full), .empty(b_empty), .eth_ready(b_ready),
      .rd_en(b_rd_en), .eth_en(b_eth_en), .ch_sel(b_ch_sel), .sop(b_sop),
      .eop(b_eop), .abort(b_abort));

   burst_read_ctrl #(.NUM_CH(1), .BURST_LEN(1), .GAP_LEN(0), .CNT_W(2)) u_c (
      .clk(clk), .rstn(rstn), .full(c_full), .empty(c_empty), .eth_ready(c_ready),
      .rd_en(c_rd_en), .eth_en(c_eth_en), .ch_sel(c_ch_sel), .sop(c_sop),
      .eop(c_eop), .abort(c_abort));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] a_vec();
      return {a_eth_en, a_rd_en, a_sop, a_eop, a_abort};
   endfunction

   function automatic logic [4:0] c_vec();
      return {c_eth_en, c_rd_en, c_sop, c_eop, c_abort};
   endfunction

   task automatic idle_all();
      a_full = 1'b0;  a_empty = 1'b1;  a_ready = 1'b0;
      b_full = 3'b0;  b_empty = 3'b111; b_ready = 1'b0;
      c_full = 1'b0;  c_empty = 1'b1;  c_ready = 1'b0;
   endtask

   // Ends on a falling edge with rstn just released: that cycle is IDLE
   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   int e_seq[7] = '{0, 1, 2, 0, 2, 2, 2};

   initial begin
      logic       bt;
      logic [4:0] ev;
      int         ph, nb, ch;

      // Reset state with eligible inputs applied
      idle_all();
      a_full = 1'b1; a_empty = 1'b0; a_ready = 1'b1;
      b_full = 3'b111; b_empty = 3'b000; b_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_a_out", 32'(a_vec()), 32'h0);
      chk("rst_a_sel", 32'(a_ch_sel), 32'h0);
      chk("rst_b_rd",  32'({b_rd_en, b_eth_en, b_sop, b_eop, b_abort}), 32'h0);
      chk("rst_b_sel", 32'(b_ch_sel), 32'h0);

      // Continuous bursts: IDLE, 4 beats, 3 GAP, repeat every 8 cycles
      idle_all();
      do_reset();
      a_full = 1'b1; a_empty = 1'b0; a_ready = 1'b1;
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         ph = c % 8;
         bt = (ph >= 1) && (ph <= 4);
         ev = {bt, bt, ph == 1, ph == 4, 1'b0};
         chk($sformatf("burst_c%0d", c), 32'(a_vec()), 32'(ev));
      end

      // Stalls: ready 1,0,1,0,1,0,1 in READ gives 4 beats over 7 cycles
      idle_all();
      do_reset();
      a_full = 1'b1; a_empty = 1'b0; a_ready = 1'b1;
      nb = 0;
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) @(negedge clk);
         a_ready = (c == 0) || (c == 8) || (c % 2 == 1);
         #1;
         bt = (c >= 1) && (c <= 7) && (c % 2 == 1);
         ev = {bt, bt, c == 1, c == 7, 1'b0};
         chk($sformatf("stall_c%0d", c), 32'(a_vec()), 32'(ev));
         if (a_eth_en) nb++;
      end
      chk("stall_beats", 32'(nb), 32'd4);

      // Empty after two beats: abort with ready high, no eop, no GAP
      idle_all();
      do_reset();
      a_full = 1'b1; a_empty = 1'b0; a_ready = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         if (c > 0) @(negedge clk);
         a_empty = (c == 3);
         #1;
         case (c)
            1:       ev = 5'b11100;
            2:       ev = 5'b11000;
            3:       ev = 5'b00001;
            5:       ev = 5'b11100;
            default: ev = 5'b00000;
         endcase
         chk($sformatf("abort_c%0d", c), 32'(a_vec()), 32'(ev));
      end

      // Round-robin over 3 channels, then only channel 2 eligible
      idle_all();
      do_reset();
      b_full = 3'b111; b_empty = 3'b000; b_ready = 1'b1;
      for (int c = 0; c <= 43; c++) begin
         if (c > 0) @(negedge clk);
         b_full = (c >= 23) ? 3'b100 : 3'b111;
         #1;
         ph = c % 7;
         ch = e_seq[c / 7];
         bt = (ph >= 1) && (ph <= 4);
         chk($sformatf("rr_c%0d", c), 32'({b_eth_en, b_rd_en, b_sop, b_eop, b_abort}),
             32'({bt, bt ? (3'b001 << ch) : 3'b000, ph == 1, ph == 4, 1'b0}));
         if (ph == 1) chk($sformatf("rr_sel_c%0d", c), 32'(b_ch_sel), 32'(ch));
      end

      // Reset mid-burst on channel 1: outputs drop at once, next grant is channel 0
      idle_all();
      do_reset();
      b_full = 3'b111; b_empty = 3'b000; b_ready = 1'b1;
      for (int c = 1; c <= 9; c++) @(negedge clk);
      #1;
      chk("mid_pre_rd", 32'(b_rd_en), 32'b010);
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_out", 32'({b_rd_en, b_eth_en, b_sop, b_eop, b_abort}), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("mid_idle", 32'({b_rd_en, b_eth_en}), 32'h0);
      @(negedge clk);
      #1;
      chk("mid_regrant_sel", 32'(b_ch_sel), 32'd0);
      chk("mid_regrant_rd", 32'({b_rd_en, b_sop}), 32'({3'b001, 1'b1}));

      // Single-beat bursts, no gap: sop and eop together every other cycle
      idle_all();
      do_reset();
      c_full = 1'b1; c_empty = 1'b0; c_ready = 1'b1;
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         bt = (c % 2 == 1);
         chk($sformatf("single_c%0d", c), 32'(c_vec()), 32'({bt, bt, bt, bt, 1'b0}));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
